decode_basic: RTL

DECODE_BASIC -- requirements
Module: decode_basic

---
 rtl/decode_basic_pkg.sv | 38 +++
 rtl/reg_file.sv | 38 +++
 rtl/decode_basic.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/decode_basic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decode_basic_pkg
// Description : Shared RV32 ISA definitions for the decode stage: the micro-op
//               type handed to execute, the opcode/funct encodings recognised
//               by decode, and immediate-extraction helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package decode_basic_pkg;

    typedef enum logic [1:0] {
        UOP_ADD  = 2'd0,
        UOP_ADDI = 2'd1,
        UOP_MUL  = 2'd2,
        UOP_LUI  = 2'd3
    } rv_uop;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;

    // ADD, ADDI and MUL all use funct3 = 000; funct7 separates ADD from MUL.
    localparam logic [2:0] c_F3_ADD    = 3'b000;
    localparam logic [6:0] c_F7_BASE   = 7'b0000000;
    localparam logic [6:0] c_F7_MULDIV = 7'b0000001;

    // I-type immediate, sign-extended to 32 bits.
    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    // U-type immediate: upper 20 bits in place, low 12 bits zero.
    function automatic logic [31:0] imm_u(input logic [31:0] inst);
        return {inst[31:12], 12'b0};
    endfunction

endpackage : decode_basic_pkg
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : 32-entry integer register file. Two combinational read ports,
//               one synchronous write port. x0 always reads as zero and is
//               never written. Contents are not reset.
// Ports       : clk            - clock
//               raddr1/rdata1  - read port 1
//               raddr2/rdata2  - read port 2
//               wen/waddr/wdata - write port (posedge)
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_BITS = 32
) (
    input  logic                 clk,
    input  logic [4:0]           raddr1,
    output logic [DATA_BITS-1:0] rdata1,
    input  logic [4:0]           raddr2,
    output logic [DATA_BITS-1:0] rdata2,
    input  logic                 wen,
    input  logic [4:0]           waddr,
    input  logic [DATA_BITS-1:0] wdata
);

    logic [DATA_BITS-1:0] r_regs [0:31];

    always_ff @(posedge clk) begin
        if (wen && (waddr != 5'd0)) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? '0 : r_regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? '0 : r_regs[raddr2];

endmodule : reg_file
`default_nettype wire

// File: rtl/decode_basic.sv
`default_nettype none
// ============================================================================
// Module      : decode_basic
// Description : Single-entry RV32 decode stage. Holds one fetched instruction,
//               decodes ADD/ADDI/MUL/LUI, reads operands (with completion
//               bypass), tracks outstanding writes in a pending scoreboard and
//               stalls on hazards. Squash from execute empties the stage and is
//               forwarded to fetch.
// Ports       : clk, rst                    - clock, async active-high reset
//               f_val/f_rdy/f_inst/f_pc     - fetch stream in
//               f_squash/f_branch_target    - redirect to fetch
//               x_val/x_rdy/x_pc/x_op1/x_op2/x_uop/x_waddr/x_wen - execute out
//               x_squash/x_branch_target    - squash from execute
//               c_val/c_waddr/c_wdata       - completion/writeback
// Revision    : 1.0 - initial release
// ============================================================================
module decode_basic
    import decode_basic_pkg::*;
#(
    parameter int p_addr_bits = 32,
    parameter int p_data_bits = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   f_val,
    output logic                   f_rdy,
    input  logic [31:0]            f_inst,
    input  logic [p_addr_bits-1:0] f_pc,
    output logic                   f_squash,
    output logic [p_addr_bits-1:0] f_branch_target,
    output logic                   x_val,
    input  logic                   x_rdy,
    output logic [p_addr_bits-1:0] x_pc,
    output logic [p_data_bits-1:0] x_op1,
    output logic [p_data_bits-1:0] x_op2,
    output rv_uop                  x_uop,
    output logic [4:0]             x_waddr,
    output logic                   x_wen,
    input  logic                   x_squash,
    input  logic [p_addr_bits-1:0] x_branch_target,
    input  logic                   c_val,
    input  logic [4:0]             c_waddr,
    input  logic [p_data_bits-1:0] c_wdata
);

    logic                   r_d_val;
    logic [31:0]            r_inst;
    logic [p_addr_bits-1:0] r_pc;
    logic [31:0]            r_pend;

    logic [6:0]             w_opcode;
    logic [6:0]             w_funct7;
    logic [2:0]             w_funct3;
    logic [4:0]             w_rs1;
    logic [4:0]             w_rs2;
    logic [4:0]             w_rd;
    rv_uop                  w_uop;
    logic                   w_use_rs1;
    logic                   w_use_rs2;
    logic                   w_writes;
    logic [p_data_bits-1:0] w_imm;
    logic [p_data_bits-1:0] w_rf_rd1;
    logic [p_data_bits-1:0] w_rf_rd2;
    logic [p_data_bits-1:0] w_src1;
    logic [p_data_bits-1:0] w_src2;
    logic                   w_rs1_ready;
    logic                   w_rs2_ready;
    logic                   w_hazard;
    logic                   w_issue;
    logic                   w_capture;
    logic [31:0]            w_pend_set;
    logic [31:0]            w_pend_clr;

    assign w_opcode = r_inst[6:0];
    assign w_rd     = r_inst[11:7];
    assign w_funct3 = r_inst[14:12];
    assign w_rs1    = r_inst[19:15];
    assign w_rs2    = r_inst[24:20];
    assign w_funct7 = r_inst[31:25];

    // Unrecognised encodings fall through as ADDI x0,x0,0: no sources, no write.
    always_comb begin
        w_uop     = UOP_ADDI;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_writes  = 1'b0;
        w_imm     = '0;
        case (w_opcode)
            c_OPC_OP: begin
                if (w_funct3 == c_F3_ADD && w_funct7 == c_F7_BASE) begin
                    w_uop     = UOP_ADD;
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_writes  = 1'b1;
                end else if (w_funct3 == c_F3_ADD && w_funct7 == c_F7_MULDIV) begin
                    w_uop     = UOP_MUL;
                    w_use_rs1 = 1'b1;
                    w_use_rs2 = 1'b1;
                    w_writes  = 1'b1;
                end
            end
            c_OPC_OP_IMM: begin
                if (w_funct3 == c_F3_ADD) begin
                    w_uop     = UOP_ADDI;
                    w_use_rs1 = 1'b1;
                    w_writes  = 1'b1;
                    w_imm     = p_data_bits'($signed(imm_i(r_inst)));
                end
            end
            c_OPC_LUI: begin
                w_uop    = UOP_LUI;
                w_writes = 1'b1;
                w_imm    = p_data_bits'($signed(imm_u(r_inst)));
            end
            default: ;
        endcase
    end

    reg_file #(
        .DATA_BITS (p_data_bits)
    ) u_reg_file (
        .clk    (clk),
        .raddr1 (w_rs1),
        .rdata1 (w_rf_rd1),
        .raddr2 (w_rs2),
        .rdata2 (w_rf_rd2),
        .wen    (c_val),
        .waddr  (c_waddr),
        .wdata  (c_wdata)
    );

    // Completion data arriving this cycle has not reached the array yet.
    assign w_src1 = (c_val && c_waddr == w_rs1 && w_rs1 != 5'd0) ? c_wdata : w_rf_rd1;
    assign w_src2 = (c_val && c_waddr == w_rs2 && w_rs2 != 5'd0) ? c_wdata : w_rf_rd2;

    assign x_op1   = w_use_rs1 ? w_src1 : '0;
    assign x_op2   = w_use_rs2 ? w_src2 : w_imm;
    assign x_pc    = r_pc;
    assign x_uop   = w_uop;
    assign x_waddr = w_writes ? w_rd : 5'd0;
    assign x_wen   = w_writes && (w_rd != 5'd0);

    // A source being completed this cycle is usable via the bypass; the
    // destination check has no such exemption to keep write order simple.
    assign w_rs1_ready = !r_pend[w_rs1] || (c_val && c_waddr == w_rs1);
    assign w_rs2_ready = !r_pend[w_rs2] || (c_val && c_waddr == w_rs2);
    assign w_hazard    = (w_use_rs1 && !w_rs1_ready)
                      || (w_use_rs2 && !w_rs2_ready)
                      || (x_wen && r_pend[w_rd]);

    assign x_val     = r_d_val && !w_hazard && !x_squash;
    assign w_issue   = x_val && x_rdy;
    assign f_rdy     = !r_d_val || w_issue;
    assign w_capture = f_val && f_rdy && !x_squash;

    assign f_squash        = x_squash && !rst;
    assign f_branch_target = x_branch_target;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d_val <= 1'b0;
        end else if (x_squash) begin
            r_d_val <= 1'b0;
        end else if (w_capture) begin
            r_d_val <= 1'b1;
        end else if (w_issue) begin
            r_d_val <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while r_d_val is set.
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_inst <= f_inst;
            r_pc   <= f_pc;
        end
    end

    assign w_pend_set = (w_issue && x_wen) ? (32'd1 << w_rd) : 32'd0;
    assign w_pend_clr = c_val ? (32'd1 << c_waddr) : 32'd0;

    // Set applied after clear so a same-cycle set/clear of one bit leaves it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_pend_clr) | w_pend_set;
        end
    end

endmodule : decode_basic
`default_nettype wire
